// File: rtl/vae_pkg.sv
// Shared types, network dimensions, fixed Q8.8 weights and the saturation
// helper for the 9->3->2 VAE encoder.
package vae_pkg;

    localparam int FRAC_BITS = 8;
    localparam int HIDDEN    = 3;
    localparam int LATENT    = 2;
    localparam int NPIX      = 9;

    typedef logic signed [15:0] q88_t;

    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_L1   = 3'd1,
        ST_ACT  = 3'd2,
        ST_L2   = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // Row j of the image excites hidden unit j (+1.0); every other pixel inhibits it (-0.25).
    localparam q88_t W1 [0:HIDDEN-1][0:NPIX-1] = '{
        '{16'sh0100, 16'sh0100, 16'sh0100, 16'shFFC0, 16'shFFC0, 16'shFFC0, 16'shFFC0, 16'shFFC0, 16'shFFC0},
        '{16'shFFC0, 16'shFFC0, 16'shFFC0, 16'sh0100, 16'sh0100, 16'sh0100, 16'shFFC0, 16'shFFC0, 16'shFFC0},
        '{16'shFFC0, 16'shFFC0, 16'shFFC0, 16'shFFC0, 16'shFFC0, 16'shFFC0, 16'sh0100, 16'sh0100, 16'sh0100}
    };

    localparam q88_t B1 [0:HIDDEN-1] = '{16'sh0000, 16'sh0000, 16'sh0000};

    localparam q88_t W2 [0:LATENT-1][0:HIDDEN-1] = '{
        '{16'sh0100, 16'sh0080, 16'shFF00},
        '{16'shFF80, 16'sh0100, 16'sh0040}
    };

    localparam q88_t B2 [0:LATENT-1] = '{16'sh0020, 16'shFFE0};

    // Clamp a 24-bit signed intermediate into the Q8.8 range.
    function automatic q88_t sat16(input logic signed [23:0] x);
        q88_t r;
        if (x > 24'sh007FFF) begin
            r = 16'sh7FFF;
        end else if (x < 24'shFF8000) begin
            r = 16'sh8000;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/vae_mac.sv
// Output-neuron MAC: signed 16x16 multiply, arithmetic shift back to Q8.8,
// 24-bit accumulate, and bias-add with saturation on the result.
import vae_pkg::*;

module vae_mac (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    input  q88_t i_a,
    input  q88_t i_b,
    input  q88_t i_bias,
    output q88_t o_result
);

    logic signed [31:0] w_prod;
    logic signed [23:0] w_term;
    logic signed [23:0] r_acc;

    assign w_prod   = 32'(i_a) * 32'(i_b);
    // >>> on a signed product truncates toward minus infinity.
    assign w_term   = 24'(w_prod >>> FRAC_BITS);
    assign o_result = sat16(r_acc + 24'(i_bias));

    // Accumulator: cleared at the start of each pass, summed during L2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 24'sd0;
        end else if (i_clear) begin
            r_acc <= 24'sd0;
        end else if (i_en) begin
            r_acc <= r_acc + w_term;
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/vae_encoder.sv
// Free-running 9->3->2 fixed-point VAE encoder. A 15-cycle pass
// (LOAD, 9x L1, ACT, 3x L2, OUT) repeats continuously; a1/a2 only change at OUT.
// Build macro: ENCODER_RELU_EN -- when defined, ACT applies max(0, x) to the
// hidden values; otherwise the hidden layer is linear.
import vae_pkg::*;

module vae_encoder #(
    parameter int N     = 9,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] a2
);

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_step;
    logic [3:0]         w_next_step;
    logic [N-1:0]       r_in;
    logic signed [19:0] r_acc1 [0:HIDDEN-1];
    q88_t               r_h    [0:HIDDEN-1];
    q88_t               w_sat  [0:HIDDEN-1];
    q88_t               w_hid  [0:HIDDEN-1];
    q88_t               w_w2   [0:LATENT-1];
    q88_t               w_res  [0:LATENT-1];
    q88_t               w_hsel;
    logic               w_mac_clr;
    logic               w_mac_en;

    // State and step registers; reset parks the FSM in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_step  <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_step  <= w_next_step;
        end
    end

    // Next-state and step sequencing for one 15-cycle pass.
    always_comb begin
        w_next_state = r_state;
        w_next_step  = r_step;
        case (r_state)
            ST_LOAD: begin
                w_next_state = ST_L1;
                w_next_step  = 4'd0;
            end
            ST_L1: begin
                if (r_step == 4'd8) begin
                    w_next_state = ST_ACT;
                    w_next_step  = 4'd0;
                end else begin
                    w_next_step  = r_step + 4'd1;
                end
            end
            ST_ACT: begin
                w_next_state = ST_L2;
                w_next_step  = 4'd0;
            end
            ST_L2: begin
                if (r_step == 4'd2) begin
                    w_next_state = ST_OUT;
                    w_next_step  = 4'd0;
                end else begin
                    w_next_step  = r_step + 4'd1;
                end
            end
            ST_OUT: begin
                w_next_state = ST_LOAD;
                w_next_step  = 4'd0;
            end
            default: begin
                w_next_state = ST_LOAD;
                w_next_step  = 4'd0;
            end
        endcase
    end

    // Hidden activation: bias, saturate, then optional ReLU.
    always_comb begin
        for (int j = 0; j < HIDDEN; j++) begin
            w_sat[j] = sat16(24'(r_acc1[j]) + 24'(B1[j]));
`ifdef ENCODER_RELU_EN
            if (w_sat[j][15]) begin
                w_hid[j] = 16'sh0000;
            end else begin
                w_hid[j] = w_sat[j];
            end
`else
            w_hid[j] = w_sat[j];
`endif
        end
    end

    // Operand select for the shared L2 multipliers, indexed by hidden unit.
    always_comb begin
        w_hsel = 16'sh0000;
        for (int k = 0; k < LATENT; k++) begin
            w_w2[k] = 16'sh0000;
        end
        case (r_step[1:0])
            2'd0: begin
                w_hsel = r_h[0];
                for (int k = 0; k < LATENT; k++) w_w2[k] = W2[k][0];
            end
            2'd1: begin
                w_hsel = r_h[1];
                for (int k = 0; k < LATENT; k++) w_w2[k] = W2[k][1];
            end
            2'd2: begin
                w_hsel = r_h[2];
                for (int k = 0; k < LATENT; k++) w_w2[k] = W2[k][2];
            end
            default: begin
                w_hsel = 16'sh0000;
            end
        endcase
    end

    assign w_mac_clr = (r_state == ST_LOAD);
    assign w_mac_en  = (r_state == ST_L2);

    for (genvar k = 0; k < LATENT; k++) begin : g_mac
        vae_mac u_mac (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (w_mac_clr),
            .i_en     (w_mac_en),
            .i_a      (w_hsel),
            .i_b      (w_w2[k]),
            .i_bias   (B2[k]),
            .o_result (w_res[k])
        );
    end

    // Datapath: input capture, layer-1 accumulation, hidden latch, output load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in <= '0;
            a1   <= '0;
            a2   <= '0;
            for (int j = 0; j < HIDDEN; j++) begin
                r_acc1[j] <= 20'sd0;
                r_h[j]    <= 16'sh0000;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_in <= in;
                    for (int j = 0; j < HIDDEN; j++) begin
                        r_acc1[j] <= 20'sd0;
                    end
                end
                ST_L1: begin
                    for (int j = 0; j < HIDDEN; j++) begin
                        r_acc1[j] <= r_acc1[j] + (r_in[r_step] ? 20'(W1[j][r_step]) : 20'sd0);
                    end
                end
                ST_ACT: begin
                    for (int j = 0; j < HIDDEN; j++) begin
                        r_h[j] <= w_hid[j];
                    end
                end
                ST_OUT: begin
                    a1 <= w_res[0];
                    a2 <= w_res[1];
                end
                default: begin
                    r_in <= r_in;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vae_encoder.sv
// Directed, table-driven bench for vae_encoder plus hand-written timing,
// mid-pass reset and input-toggle sequences.
module tb_vae_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  pix = 9'd0;
    logic [15:0] a1;
    logic [15:0] a2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [8:0]  pix;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs [7];

    vae_encoder #(.N(9), .WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .in  (pix),
        .a1  (a1),
        .a2  (a2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two edges with the new pixels applied, then release.
    // The next tick() is the first LOAD edge of the pass.
    task automatic start(input logic [8:0] p);
        rst = 1'b1;
        pix = p;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{9'b011101111, 16'h01C0, 16'hFFD0};
        vecs[1] = '{9'h000,       16'h0020, 16'hFFE0};
        vecs[2] = '{9'h1FF,       16'h00E0, 16'h0100};
`ifdef ENCODER_RELU_EN
        vecs[3] = '{9'b000000001, 16'h0120, 16'hFF60};
        vecs[4] = '{9'b000000111, 16'h0320, 16'hFE60};
        vecs[5] = '{9'b111000000, 16'hFD20, 16'h00A0};
        vecs[6] = '{9'b000111000, 16'h01A0, 16'h02E0};
`else
        vecs[3] = '{9'b000000001, 16'h0140, 16'hFF10};
        vecs[4] = '{9'b000000111, 16'h0380, 16'hFD70};
        vecs[5] = '{9'b111000000, 16'hFC00, 16'h0040};
        vecs[6] = '{9'b000111000, 16'h01A0, 16'h0310};
`endif

        // Reset state
        repeat (3) tick();
        check("reset_a1", a1, 16'h0000);
        check("reset_a2", a2, 16'h0000);

        // Output timing: zero for cycles 1..14, value at 15, held until 30.
        start(9'b011101111);
        for (int c = 1; c <= 14; c++) begin
            tick();
            check($sformatf("timing_zero_a1_c%0d", c), a1, 16'h0000);
            check($sformatf("timing_zero_a2_c%0d", c), a2, 16'h0000);
        end
        tick();
        check("timing_c15_a1", a1, 16'h01C0);
        check("timing_c15_a2", a2, 16'hFFD0);
        for (int c = 16; c <= 30; c++) begin
            tick();
            check($sformatf("hold_a1_c%0d", c), a1, 16'h01C0);
            check($sformatf("hold_a2_c%0d", c), a2, 16'hFFD0);
        end

        // Table of directed vectors, one pass each from reset.
        for (int v = 0; v < 7; v++) begin
            start(vecs[v].pix);
            repeat (15) tick();
            check($sformatf("vec%0d_a1", v), a1, vecs[v].e1);
            check($sformatf("vec%0d_a2", v), a2, vecs[v].e2);
        end

        // Mid-pass reset: outputs hold vec6 result, abort at cycle 8 of next pass.
        repeat (8) tick();
        check("pre_abort_a1", a1, vecs[6].e1);
        rst = 1'b1;
        pix = vecs[2].pix;
        tick();
        check("abort_a1", a1, 16'h0000);
        check("abort_a2", a2, 16'h0000);
        rst = 1'b0;
        repeat (14) tick();
        check("abort_c14_a1", a1, 16'h0000);
        tick();
        check("abort_c15_a1", a1, vecs[2].e1);
        check("abort_c15_a2", a2, vecs[2].e2);

        // Input toggle during L1: this pass uses old input, next pass new input.
        start(vecs[4].pix);
        repeat (5) tick();
        pix = vecs[5].pix;
        repeat (10) tick();
        check("toggle_old_a1", a1, vecs[4].e1);
        check("toggle_old_a2", a2, vecs[4].e2);
        repeat (15) tick();
        check("toggle_new_a1", a1, vecs[5].e1);
        check("toggle_new_a2", a2, vecs[5].e2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
